map_loader: RTL and testbench
=============================

# map_loader

Streams a golf-course terrain map into the terrain BRAM that the gameplay engine reads for hole, wall, grass and sand detection. It takes a byte stream, typically from the UART receiver, framed as magic byte, packed payload, then XOR checksum. Each payload byte is unpacked into four 2-bit tile codes, written one tile per cycle on the write port of the map RAM. The gameplay block is held in reset until `done_out` is asserted.

## Interface
- `WIDTH`, default 160: map width in tiles.
- `HEIGHT`, default 90: map height in tiles. `WIDTH*HEIGHT` must be divisible by 4.
- `MAGIC`, default 8'hA5: frame start byte.
- `clk_in`, input, 1: system clock. All logic is on its rising edge.
- `rst_n_in`, input, 1: reset, asynchronous and active-low.
- `start_in`, input, 1: begin a new load. Level-sampled each cycle.
- `byte_in`, input, 8: stream data.
- `byte_valid_in`, input, 1: `byte_in` is valid.
- `byte_ready_out`, output, 1: loader can accept a byte. A byte transfers on a cycle where both valid and ready are high.
- `map_addr_out`, output, 16: tile address, equal to x + WIDTH*y.
- `map_data_out`, output, 2: terrain code. 0 = hole, 1 = wall, 2 = grass, 3 = sand.
- `map_we_out`, output, 1: write strobe for the map RAM.
- `busy_out`, output, 1: a load is in progress.
- `done_out`, output, 1: last load completed with a good checksum. Sticky.
- `error_out`, output, 1: last load completed with a checksum mismatch. Sticky.

## Operation
- `NBYTES = WIDTH*HEIGHT/4`. This is 3600 at the default parameters.
- Frame format: `MAGIC`, then `NBYTES` payload bytes, then one checksum byte. The checksum is the XOR of all payload bytes.
- Payload byte k covers tiles 4k to 4k+3. Bits [1:0] go to tile 4k, [3:2] to 4k+1, [5:4] to 4k+2, [7:6] to 4k+3.
- IDLE:
  - ready = 0, busy = 0.
  - `start_in` high: clear done and error, clear the byte counter and checksum, go to WAIT_MAGIC.
- WAIT_MAGIC:
  - ready = 1, busy = 1.
  - Accepted byte equal to `MAGIC`: go to RECV.
  - Any other accepted byte is discarded with no write, and the state stays WAIT_MAGIC (resync).
- RECV:
  - ready = 1.
  - On accept: latch the byte, XOR it into the checksum, set sub = 0, go to UNPACK.
- UNPACK:
  - ready = 0.
  - Each cycle writes one tile: `map_we_out` = 1, `map_addr_out` = 4k + sub, `map_data_out` = byte[2*sub+1 : 2*sub].
  - After sub = 3, increment k. If k = `NBYTES` go to WAIT_CSUM, otherwise go to RECV.
- WAIT_CSUM:
  - ready = 1.
  - On accept: if the byte equals the running checksum, set done = 1; otherwise set error = 1. Go to IDLE.
  - Tiles already written are not rolled back.
- `start_in` is ignored while busy. It is honoured in IDLE regardless of the done/error state.
- In every state other than UNPACK, `map_we_out` = 0.
- The byte counter is 16-bit. The address 4k+sub is computed at 16-bit width, and its maximum is `WIDTH*HEIGHT-1`.

## Timing
- Reset values: `byte_ready_out` = 0, `map_we_out` = 0, `map_addr_out` = 0, `map_data_out` = 0, `busy_out` = 0, `done_out` = 0, `error_out` = 0. The state is IDLE.
- All outputs are registered, and no output is combinationally dependent on the inputs.
- `busy_out` rises the cycle after `start_in` is sampled in IDLE. It falls on the same edge that done or error is set.
- Per payload byte:
  - Accept edge at cycle N.
  - `map_we_out` is high for cycles N+1 through N+4, with consecutive addresses.
  - `byte_ready_out` is high again at N+5 at the earliest.
- Throughput is 5 cycles per byte minimum. A full default map loads in at least 2 + 5·3600 cycles after the magic byte.
- `byte_valid_in` may drop at any time. The loader waits indefinitely and has no timeout.
- Asserting `rst_n_in` mid-load returns the block to IDLE immediately and clears all outputs. Partial RAM contents are left as written.

## Test plan
- Reset: hold `rst_n_in` low with `byte_valid_in` = 1 and `start_in` = 1. Required: every output stays 0 and no write occurs.
- Good frame, `WIDTH` = 4, `HEIGHT` = 2: pulse `start_in`, then send A5, E4, 1B, FF. Required:
  - writes to addr 0–7 with data 0,1,2,3,3,2,1,0;
  - `done_out` = 1, `error_out` = 0, `busy_out` = 0.
- Resync: send 00, 12, A5, E4, 1B, FF after start. Required: the first two bytes are accepted with no write, then the result matches the good-frame case.
- Bad checksum: send A5, E4, 1B, 00. Required:
  - all 8 writes occur;
  - `error_out` = 1, `done_out` = 0.
  - A following good frame clears error and sets done.
- Stalls and handshake:
  - Insert gaps of 0–7 cycles in `byte_valid_in`. Required: `byte_ready_out` = 0 during every UNPACK cycle, exactly 4 writes per byte, and the same final RAM image as the good frame.
  - Pulse `start_in` mid-frame. Required: it is ignored.
- Reset mid-load: assert `rst_n_in` after the first payload byte. Required:
  - outputs return to 0 asynchronously;
  - writes stop after the reset;
  - a fresh start plus a good frame then completes with done = 1.

Source files
------------

// File: rtl/map_loader.sv
// Terrain map loader: receives a framed byte stream (magic, packed payload, XOR checksum)
// and unpacks each payload byte into four 2-bit tile writes on the map RAM write port.
module map_loader #(
    parameter int         WIDTH  = 160,
    parameter int         HEIGHT = 90,
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        byte_ready_out,
    output logic [15:0] map_addr_out,
    output logic [1:0]  map_data_out,
    output logic        map_we_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        error_out
);

    localparam int          NTILES = WIDTH * HEIGHT;
    localparam logic [15:0] NBYTES = 16'(NTILES / 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MAGIC,
        S_RECV,
        S_UNPACK,
        S_WAIT_CSUM
    } state_t;

    state_t      r_state;
    logic [1:0]  r_sub;
    logic [15:0] r_k;
    logic [7:0]  r_byte;
    logic [7:0]  r_csum;
    logic        r_done;
    logic        r_error;
    logic        r_ready;
    logic        r_busy;
    logic        r_we;
    logic [15:0] r_addr;
    logic [1:0]  r_data;

    state_t      w_state_nx;
    logic [1:0]  w_sub_nx;
    logic [15:0] w_k_nx;
    logic [7:0]  w_byte_nx;
    logic [7:0]  w_csum_nx;
    logic        w_done_nx;
    logic        w_error_nx;
    logic        w_ready_nx;
    logic        w_busy_nx;
    logic        w_we_nx;
    logic [15:0] w_addr_nx;
    logic [1:0]  w_data_nx;
    logic [7:0]  w_shifted;
    logic [15:0] w_k_inc;
    logic        w_accept;

    // A transfer uses the registered ready that the sender actually sees.
    assign w_accept = byte_valid_in & r_ready;
    assign w_k_inc  = r_k + 16'd1;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        w_state_nx = r_state;
        w_sub_nx   = r_sub;
        w_k_nx     = r_k;
        w_byte_nx  = r_byte;
        w_csum_nx  = r_csum;
        w_done_nx  = r_done;
        w_error_nx = r_error;

        unique case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_done_nx  = 1'b0;
                    w_error_nx = 1'b0;
                    w_k_nx     = 16'd0;
                    w_csum_nx  = 8'd0;
                    w_state_nx = S_WAIT_MAGIC;
                end
            end
            S_WAIT_MAGIC: begin
                if (w_accept && byte_in == MAGIC) w_state_nx = S_RECV;
            end
            S_RECV: begin
                if (w_accept) begin
                    w_byte_nx  = byte_in;
                    w_csum_nx  = r_csum ^ byte_in;
                    w_sub_nx   = 2'd0;
                    w_state_nx = S_UNPACK;
                end
            end
            S_UNPACK: begin
                w_sub_nx = r_sub + 2'd1;
                if (r_sub == 2'd3) begin
                    w_k_nx     = w_k_inc;
                    w_state_nx = (w_k_inc == NBYTES) ? S_WAIT_CSUM : S_RECV;
                end
            end
            S_WAIT_CSUM: begin
                if (w_accept) begin
                    if (byte_in == r_csum) w_done_nx  = 1'b1;
                    else                   w_error_nx = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        w_ready_nx = (w_state_nx == S_WAIT_MAGIC) || (w_state_nx == S_RECV) ||
                     (w_state_nx == S_WAIT_CSUM);
        w_busy_nx  = (w_state_nx != S_IDLE);
        w_we_nx    = (w_state_nx == S_UNPACK);
        w_shifted  = w_byte_nx >> {w_sub_nx, 1'b0};
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        if (w_we_nx) begin
            w_addr_nx = (w_k_nx << 2) | {14'd0, w_sub_nx};
            w_data_nx = w_shifted[1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_sub   <= 2'd0;
            r_k     <= 16'd0;
            r_byte  <= 8'd0;
            r_csum  <= 8'd0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 16'd0;
            r_data  <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_sub   <= w_sub_nx;
            r_k     <= w_k_nx;
            r_byte  <= w_byte_nx;
            r_csum  <= w_csum_nx;
            r_done  <= w_done_nx;
            r_error <= w_error_nx;
            r_ready <= w_ready_nx;
            r_busy  <= w_busy_nx;
            r_we    <= w_we_nx;
            r_addr  <= w_addr_nx;
            r_data  <= w_data_nx;
        end
    end

    assign byte_ready_out = r_ready;
    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign error_out      = r_error;
    assign map_we_out     = r_we;
    assign map_addr_out   = r_addr;
    assign map_data_out   = r_data;

endmodule

// File: tb/tb_map_loader.sv
// Directed bench for map_loader on a 4x2 map: good, resync, bad-checksum, stalled
// and reset-interrupted frames, with a small RAM model capturing the writes.
module tb_map_loader;

    logic        clk_in;
    logic        rst_n_in;
    logic        start_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic [15:0] map_addr_out;
    logic [1:0]  map_data_out;
    logic        map_we_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;

    map_loader #(.WIDTH(4), .HEIGHT(2), .MAGIC(8'hA5)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .byte_ready_out (byte_ready_out),
        .map_addr_out   (map_addr_out),
        .map_data_out   (map_data_out),
        .map_we_out     (map_we_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Tile RAM model; 3'd7 marks a tile never written since the last clear.
    logic [2:0] mem [8];
    int         wr_cnt;
    int         addr_err;
    int         ready_err;
    logic [1:0] exp_img [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

    initial begin
        wr_cnt    = 0;
        addr_err  = 0;
        ready_err = 0;
    end

    always @(negedge clk_in) begin
        if (map_we_out) begin
            if (map_addr_out != 16'(wr_cnt) || map_addr_out > 16'd7) addr_err = addr_err + 1;
            else mem[map_addr_out[2:0]] = {1'b0, map_data_out};
            if (byte_ready_out) ready_err = ready_err + 1;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mem[i] = 3'd7;
        wr_cnt    = 0;
        addr_err  = 0;
        ready_err = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk_in);
        @(negedge clk_in);
        byte_in       = b;
        byte_valid_in = 1'b1;
        n = 0;
        while (!byte_ready_out && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 200) begin
            check("ready_timeout", 32'(n), 32'd0);
            byte_valid_in = 1'b0;
        end else begin
            @(posedge clk_in);
            #1;
            byte_valid_in = 1'b0;
        end
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_tile%0d", tag, i), 32'(mem[i]), {30'd0, exp_img[i]});
        check({tag, "_writes"}, 32'(wr_cnt), 32'd8);
        check({tag, "_addr_seq"}, 32'(addr_err), 32'd0);
        check({tag, "_ready_in_unpack"}, 32'(ready_err), 32'd0);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e);
        check({tag, "_done"},  32'(done_out),  32'(d));
        check({tag, "_error"}, 32'(error_out), 32'(e));
        check({tag, "_busy"},  32'(busy_out),  32'd0);
    endtask

    task automatic good_frame(input string tag, input int max_gap);
        clear_model();
        pulse_start();
        send_byte(8'hA5, $urandom_range(0, max_gap));
        send_byte(8'hE4, $urandom_range(0, max_gap));
        send_byte(8'h1B, $urandom_range(0, max_gap));
        send_byte(8'hFF, $urandom_range(0, max_gap));
        tick();
        check_image(tag);
        check_status(tag, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n_in      = 1'b0;
        start_in      = 1'b1;
        byte_valid_in = 1'b1;
        byte_in       = 8'hA5;
        clear_model();

        // Reset held with live inputs: nothing moves.
        repeat (4) tick();
        check("rst_outputs", {25'd0, byte_ready_out, map_we_out, busy_out, done_out,
                              error_out, map_data_out}, 32'd0);
        check("rst_addr", 32'(map_addr_out), 32'd0);
        check("rst_writes", 32'(wr_cnt), 32'd0);
        start_in      = 1'b0;
        byte_valid_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
        check("idle_ready", 32'(byte_ready_out), 32'd0);

        // Good frame with explicit per-byte timing of the first payload byte.
        clear_model();
        pulse_start();
        #1;
        check("start_busy", 32'(busy_out), 32'd1);
        send_byte(8'hA5, 0);
        send_byte(8'hE4, 0);
        check("accept_edge_we", 32'(map_we_out), 32'd1);
        repeat (4) tick();
        check("unpack_writes4", 32'(wr_cnt), 32'd4);
        check("unpack_last_ready", 32'(byte_ready_out), 32'd0);
        tick();
        check("n5_ready", 32'(byte_ready_out), 32'd1);
        check("n5_we", 32'(map_we_out), 32'd0);
        send_byte(8'h1B, 0);
        send_byte(8'hFF, 0);
        check("csum_edge_done", 32'(done_out), 32'd1);
        check("csum_edge_busy", 32'(busy_out), 32'd0);
        tick();
        check_image("good");
        check_status("good", 1'b1, 1'b0);

        // Resync: junk bytes before the magic are consumed without writes.
        clear_model();
        pulse_start();
        #1;
        check("restart_clears_done", 32'(done_out), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        tick();
        check("resync_no_write", 32'(wr_cnt), 32'd0);
        check("resync_busy", 32'(busy_out), 32'd1);
        send_byte(8'hA5, 0);
        send_byte(8'hE4, 0);
        send_byte(8'h1B, 0);
        send_byte(8'hFF, 0);
        tick();
        check_image("resync");
        check_status("resync", 1'b1, 1'b0);

        // Bad checksum: tiles still written, error flagged.
        clear_model();
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'hE4, 0);
        send_byte(8'h1B, 0);
        send_byte(8'h00, 0);
        tick();
        check_image("badcsum");
        check_status("badcsum", 1'b0, 1'b1);
        good_frame("after_bad", 0);

        // Stalls with a start pulse in the middle of the frame.
        clear_model();
        pulse_start();
        send_byte(8'hA5, $urandom_range(0, 7));
        send_byte(8'hE4, $urandom_range(0, 7));
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("midstart_busy", 32'(busy_out), 32'd1);
        send_byte(8'h1B, $urandom_range(0, 7));
        send_byte(8'hFF, $urandom_range(0, 7));
        tick();
        check_image("stall");
        check_status("stall", 1'b1, 1'b0);
        good_frame("gaps", 7);

        // Reset during unpacking of the first payload byte.
        clear_model();
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'hE4, 0);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("midrst_outputs", {26'd0, byte_ready_out, map_we_out, busy_out, done_out,
                                 error_out, 1'b0}, 32'd0);
        check("midrst_addr_data", {14'd0, map_addr_out, map_data_out}, 32'd0);
        begin
            int snap;
            snap = wr_cnt;
            repeat (5) tick();
            check("midrst_writes_stop", 32'(wr_cnt), 32'(snap));
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
        check("midrst_idle_busy", 32'(busy_out), 32'd0);
        good_frame("after_rst", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
